// File: rtl/indec_if.sv
// Opcode strobe/byte from the command framing logic and the decoded command
// pulses plus trigger stage index toward the analyzer core.
interface indec_if;
   logic       stb_i;
   logic [7:0] opc_i;
   logic       sft_rst_o;
   logic       arm_o;
   logic       id_o;
   logic       rd_meta_o;
   logic       fin_now_o;
   logic       rd_inp_o;
   logic       arm_adv_o;
   logic       xon_o;
   logic       xoff_o;
   logic       set_div_o;
   logic       set_cnt_o;
   logic       set_flgs_o;
   logic       set_adv_cfg_o;
   logic       set_adv_dat_o;
   logic       set_mask_o;
   logic       set_val_o;
   logic       set_cfg_o;
   logic [1:0] stg_o;

   // Framing side: delivers opcodes and observes the decoded commands.
   modport master (
      output stb_i, opc_i,
      input  sft_rst_o, arm_o, id_o, rd_meta_o, fin_now_o, rd_inp_o,
             arm_adv_o, xon_o, xoff_o, set_div_o, set_cnt_o, set_flgs_o,
             set_adv_cfg_o, set_adv_dat_o, set_mask_o, set_val_o, set_cfg_o,
             stg_o
   );

   // Decoder side: consumes opcodes and drives the command pulses.
   modport slave (
      input  stb_i, opc_i,
      output sft_rst_o, arm_o, id_o, rd_meta_o, fin_now_o, rd_inp_o,
             arm_adv_o, xon_o, xoff_o, set_div_o, set_cnt_o, set_flgs_o,
             set_adv_cfg_o, set_adv_dat_o, set_mask_o, set_val_o, set_cfg_o,
             stg_o
   );
endinterface

// File: rtl/indec.sv
// SUMP-style instruction decoder: turns a strobed opcode byte into a single
// registered one-cycle command pulse, and latches the trigger stage index of
// mask/value/config commands so it stays valid while operand bytes arrive.
module indec (
   input  logic clk_i,
   input  logic rst_in,
   indec_if.slave bus
);

   localparam int P_SFT_RST = 0;
   localparam int P_ARM     = 1;
   localparam int P_ID      = 2;
   localparam int P_RD_META = 3;
   localparam int P_FIN_NOW = 4;
   localparam int P_RD_INP  = 5;
   localparam int P_ARM_ADV = 6;
   localparam int P_XON     = 7;
   localparam int P_XOFF    = 8;
   localparam int P_SET_DIV = 9;
   localparam int P_SET_CNT = 10;
   localparam int P_SET_FLG = 11;
   localparam int P_ADV_CFG = 12;
   localparam int P_ADV_DAT = 13;
   localparam int P_MASK    = 14;
   localparam int P_VAL     = 15;
   localparam int P_CFG     = 16;
   localparam int NPULSE    = 17;

   logic [NPULSE-1:0] pulse_d;
   logic [NPULSE-1:0] pulse_q;
   logic [1:0]        stg_d;
   logic [1:0]        stg_q;

   // Full 8-bit decode; unknown opcodes or an idle strobe yield no pulse and keep the stage.
   always_comb begin
      pulse_d = '0;
      stg_d   = stg_q;
      if (bus.stb_i) begin
         case (bus.opc_i)
            8'h00: pulse_d[P_SFT_RST] = 1'b1;
            8'h01: pulse_d[P_ARM]     = 1'b1;
            8'h02: pulse_d[P_ID]      = 1'b1;
            8'h04: pulse_d[P_RD_META] = 1'b1;
            8'h05: pulse_d[P_FIN_NOW] = 1'b1;
            8'h06: pulse_d[P_RD_INP]  = 1'b1;
            8'h0F: pulse_d[P_ARM_ADV] = 1'b1;
            8'h11: pulse_d[P_XON]     = 1'b1;
            8'h13: pulse_d[P_XOFF]    = 1'b1;
            8'h80: pulse_d[P_SET_DIV] = 1'b1;
            8'h81: pulse_d[P_SET_CNT] = 1'b1;
            8'h82: pulse_d[P_SET_FLG] = 1'b1;
            8'h9E: pulse_d[P_ADV_CFG] = 1'b1;
            8'h9F: pulse_d[P_ADV_DAT] = 1'b1;
            8'hC0, 8'hC4, 8'hC8, 8'hCC: begin
               pulse_d[P_MASK] = 1'b1;
               stg_d           = bus.opc_i[3:2];
            end
            8'hC1, 8'hC5, 8'hC9, 8'hCD: begin
               pulse_d[P_VAL] = 1'b1;
               stg_d          = bus.opc_i[3:2];
            end
            8'hC2, 8'hC6, 8'hCA, 8'hCE: begin
               pulse_d[P_CFG] = 1'b1;
               stg_d          = bus.opc_i[3:2];
            end
            default: ;
         endcase
      end
   end

   // Register pulses and stage so every output is glitch-free and one cycle behind the strobe.
   always_ff @(posedge clk_i or posedge rst_in) begin
      if (rst_in) begin
         pulse_q <= '0;
         stg_q   <= 2'b00;
      end else begin
         pulse_q <= pulse_d;
         stg_q   <= stg_d;
      end
   end

   assign bus.sft_rst_o     = pulse_q[P_SFT_RST];
   assign bus.arm_o         = pulse_q[P_ARM];
   assign bus.id_o          = pulse_q[P_ID];
   assign bus.rd_meta_o     = pulse_q[P_RD_META];
   assign bus.fin_now_o     = pulse_q[P_FIN_NOW];
   assign bus.rd_inp_o      = pulse_q[P_RD_INP];
   assign bus.arm_adv_o     = pulse_q[P_ARM_ADV];
   assign bus.xon_o         = pulse_q[P_XON];
   assign bus.xoff_o        = pulse_q[P_XOFF];
   assign bus.set_div_o     = pulse_q[P_SET_DIV];
   assign bus.set_cnt_o     = pulse_q[P_SET_CNT];
   assign bus.set_flgs_o    = pulse_q[P_SET_FLG];
   assign bus.set_adv_cfg_o = pulse_q[P_ADV_CFG];
   assign bus.set_adv_dat_o = pulse_q[P_ADV_DAT];
   assign bus.set_mask_o    = pulse_q[P_MASK];
   assign bus.set_val_o     = pulse_q[P_VAL];
   assign bus.set_cfg_o     = pulse_q[P_CFG];
   assign bus.stg_o         = stg_q;

endmodule

// File: tb/tb_indec.sv
// Self-checking bench for indec: directed steps from the test plan followed by
// random opcodes, compared against an opcode-table reference model.
module tb_indec;

   logic clk_i;
   logic rst_in;
   indec_if bus ();

   indec dut (
      .clk_i  (clk_i),
      .rst_in (rst_in),
      .bus    (bus)
   );

   // Free-running 10 ns clock.
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   // Expected state of the reference model.
   logic [16:0] exp_pulse;
   logic [1:0]  exp_stg;

   // Observed pulses gathered into one vector, bit i = command i of the opcode table.
   logic [16:0] obs_pulse;
   assign obs_pulse = {bus.set_cfg_o, bus.set_val_o, bus.set_mask_o,
                       bus.set_adv_dat_o, bus.set_adv_cfg_o, bus.set_flgs_o,
                       bus.set_cnt_o, bus.set_div_o, bus.xoff_o, bus.xon_o,
                       bus.arm_adv_o, bus.rd_inp_o, bus.fin_now_o, bus.rd_meta_o,
                       bus.id_o, bus.arm_o, bus.sft_rst_o};

   // Fixed-code commands, in output-vector order.
   logic [7:0] fixed_opc [14] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h0F,
                                  8'h11, 8'h13, 8'h80, 8'h81, 8'h82, 8'h9E, 8'h9F};

   // Which output an opcode selects, or -1 if it is not a command.
   function automatic int commandIndex(input logic [7:0] opc);
      int idx = -1;
      for (int i = 0; i < 14; i++)
         if (fixed_opc[i] == opc) idx = i;
      if (opc >= 8'hC0 && opc <= 8'hCF && (opc % 4) != 3)
         idx = 14 + int'(opc % 4);
      return idx;
   endfunction

   // Advance the model by one clock edge with the given inputs.
   function automatic void modelStep(input logic stb, input logic [7:0] opc);
      int idx;
      exp_pulse = '0;
      if (stb) begin
         idx = commandIndex(opc);
         if (idx >= 0) begin
            exp_pulse[idx] = 1'b1;
            if (idx >= 14) exp_stg = 2'((opc - 8'hC0) / 4);
         end
      end
   endfunction

   // Drive one strobe/opcode, clock it in, and leave time 1 ns past the edge.
   task automatic applyStimulus(input logic stb, input logic [7:0] opc);
      bus.stb_i = stb;
      bus.opc_i = opc;
      @(posedge clk_i);
      if (rst_in) begin
         exp_pulse = '0;
         exp_stg   = 2'b00;
      end else begin
         modelStep(stb, opc);
      end
      #1;
   endtask

   // Compare pulses and stage against the model.
   task automatic checkOutput(input string tag);
      checks++;
      assert (obs_pulse === exp_pulse)
      else begin
         failures++;
         $error("[TB] FAIL %s pulses observed=%05h expected=%05h", tag, obs_pulse, exp_pulse);
      end
      checks++;
      assert (bus.stg_o === exp_stg)
      else begin
         failures++;
         $error("[TB] FAIL %s stg observed=%0d expected=%0d", tag, bus.stg_o, exp_stg);
      end
   endtask

   // Directed test plan followed by randomized traffic.
   initial begin
      logic [7:0] op;
      logic       st;

      exp_pulse = '0;
      exp_stg   = 2'b00;

      rst_in    = 1'b1;
      bus.stb_i = 1'b1;
      bus.opc_i = 8'h01;
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("reset_hold");

      rst_in = 1'b0;
      applyStimulus(1'b1, 8'h01);
      checkOutput("first_arm");
      applyStimulus(1'b0, 8'h00);
      checkOutput("first_arm_drop");

      for (int i = 0; i < 14; i++) begin
         applyStimulus(1'b1, fixed_opc[i]);
         checkOutput($sformatf("cmd_%02h", fixed_opc[i]));
         applyStimulus(1'b0, 8'h00);
         checkOutput($sformatf("cmd_%02h_end", fixed_opc[i]));
      end

      applyStimulus(1'b1, 8'hC8);
      checkOutput("stage_mask2");
      applyStimulus(1'b1, 8'hCD);
      checkOutput("stage_val3");
      applyStimulus(1'b1, 8'hC2);
      checkOutput("stage_cfg0");
      applyStimulus(1'b1, 8'h01);
      checkOutput("stage_hold_arm");

      applyStimulus(1'b1, 8'hCD);
      checkOutput("stage_val3_again");
      applyStimulus(1'b1, 8'hC3);
      checkOutput("invalid_c3");
      applyStimulus(1'b1, 8'h03);
      checkOutput("invalid_03");
      applyStimulus(1'b1, 8'hFF);
      checkOutput("invalid_ff");
      applyStimulus(1'b0, 8'h01);
      checkOutput("no_strobe");

      applyStimulus(1'b1, 8'hC1);
      checkOutput("b2b_first");
      applyStimulus(1'b1, 8'hC1);
      checkOutput("b2b_second");
      bus.stb_i = 1'b0;
      rst_in    = 1'b1;
      #1;
      exp_pulse = '0;
      exp_stg   = 2'b00;
      checkOutput("async_reset_mid_pulse");
      @(posedge clk_i);
      #1;
      rst_in = 1'b0;

      for (int n = 0; n < 400; n++) begin
         st = 1'($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) begin
            op = fixed_opc[$urandom_range(0, 13)];
            if ($urandom_range(0, 1) == 1) op = 8'hC0 + 8'($urandom_range(0, 15));
         end else begin
            op = 8'($urandom_range(0, 255));
         end
         applyStimulus(st, op);
         checkOutput($sformatf("rand_%0d_stb%0d_%02h", n, st, op));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
